// File: rtl/instr_encoder.sv
// instr_encoder: program loader for the 16-bit RISC core.
// Takes symbolic instruction fields on a valid/ready stream, packs each
// bundle into a 16-bit word and writes the words to imem at consecutive
// addresses starting at BASE_ADDR.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   start                pulse: begin a load session (honoured in IDLE/DONE)
//   in_valid/in_ready    field bundle handshake
//   in_kind              0 = R-type (ALU), 1 = I-type/other
//   in_aluop             R-type ALU op
//   in_opcode            I-type raw opcode
//   in_rd/in_rs/in_rt    register numbers
//   in_imm               I-type signed immediate
//   in_last              final bundle of the program
//   mem_we/addr/wdata    imem write request, held until mem_ack
//   mem_ack              imem took the write this cycle
//   busy                 session in RUN or DRAIN
//   done                 one-cycle pulse after the last word is acknowledged
//   err_illegal          sticky: an illegal bundle was dropped
//   err_overflow         sticky: a write past DEPTH was dropped
//   word_count           words acknowledged this session
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kind,
  input  logic [2:0]        in_aluop,
  input  logic [3:0]        in_opcode,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0]   depth_c = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] base_c  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] last_c  = ADDR_W'(BASE_ADDR + DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Instruction word layout shared by both classes; tail is rt+000 or imm[5:0].
  typedef struct packed {
    logic [3:0] opc;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [5:0] tail;
  } iword_t;

  state_t state, state_nx;
  iword_t word;
  logic   accept, ack, legal, room, do_write, sess_start, drain_ok;

  assign accept     = in_valid && in_ready;
  assign ack        = mem_we && mem_ack;
  assign sess_start = start && (state == IDLE || state == DONE);
  assign drain_ok   = !mem_we || mem_ack;

  // Immediate fits the 6-bit field when bits 15:5 are a pure sign extension.
  assign legal = !in_kind ||
                 (!in_opcode[3] && ((&in_imm[15:5]) || !(|in_imm[15:5])));

  // A pending write (acked this cycle or not) already owns a slot, so it
  // counts against DEPTH when deciding whether this bundle may write.
  assign room     = (word_count + {{ADDR_W{1'b0}}, mem_we}) < depth_c;
  assign do_write = accept && legal && room;

  always_comb begin
    word = '0;
    if (!in_kind) word = '{opc: {1'b1, in_aluop}, rd: in_rd, rs: in_rs, tail: {in_rt, 3'b000}};
    else          word = '{opc: in_opcode,        rd: in_rd, rs: in_rs, tail: in_imm[5:0]};
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && in_last) state_nx = DRAIN;
      DRAIN:   if (drain_ok) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    in_ready = (state == RUN) && (!mem_we || mem_ack);
    busy     = (state == RUN) || (state == DRAIN);
  end

  // write port, counters and status
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_addr     <= base_c;
      mem_wdata    <= '0;
      done         <= 1'b0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
      word_count   <= '0;
    end else begin
      done <= (state == DRAIN) && drain_ok;
      if (sess_start) begin
        mem_we       <= 1'b0;
        mem_addr     <= base_c;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
        word_count   <= '0;
      end else begin
        if (ack) begin
          word_count <= word_count + 1'b1;
          // Saturate at the top of the window; no further writes can be
          // issued once the window is full.
          if (mem_addr != last_c) mem_addr <= mem_addr + 1'b1;
        end
        if (do_write) begin
          mem_we    <= 1'b1;
          mem_wdata <= word;
        end else if (ack) begin
          mem_we <= 1'b0;
        end
        if (accept && !legal)         err_illegal  <= 1'b1;
        if (accept && legal && !room) err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised scoreboard bench for instr_encoder (ADDR_W=3, BASE 0, DEPTH 4).
module tb_instr_encoder;
  localparam int P_AW    = 3;
  localparam int P_BASE  = 0;
  localparam int P_DEPTH = 4;

  typedef struct packed {
    logic        kind;
    logic [2:0]  aluop;
    logic [3:0]  opcode;
    logic [2:0]  rd, rs, rt;
    logic [15:0] imm;
    logic        last;
  } bundle_t;

  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_ready;
  logic in_kind = 0, in_last = 0, mem_ack = 0, mem_we, busy, done;
  logic [2:0] in_aluop = 0, in_rd = 0, in_rs = 0, in_rt = 0;
  logic [3:0] in_opcode = 0;
  logic [15:0] in_imm = 0, mem_wdata;
  logic [P_AW-1:0] mem_addr;
  logic [P_AW:0] word_count;
  logic err_illegal, err_overflow;

  instr_encoder #(.ADDR_W(P_AW), .BASE_ADDR(P_BASE), .DEPTH(P_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_aluop(in_aluop), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow),
    .word_count(word_count));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
  int ack_mode = 0, stall_cnt = 0, stall_obs = 0;
  logic [P_AW+15:0] sb[$];
  int  m_n;
  bit  m_ill, m_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the spec says a bundle should become.
  function automatic bit ref_legal(input bundle_t b);
    int si = int'($signed(b.imm));
    if (!b.kind) return 1;
    return (b.opcode < 8) && (si >= -32) && (si <= 31);
  endfunction

  function automatic logic [15:0] ref_word(input bundle_t b);
    int w;
    if (!b.kind) w = 32768 + int'(b.aluop)*4096 + int'(b.rd)*512 + int'(b.rs)*64 + int'(b.rt)*8;
    else         w = int'(b.opcode)*4096 + int'(b.rd)*512 + int'(b.rs)*64 + (int'($signed(b.imm)) & 63);
    return w[15:0];
  endfunction

  task automatic model_accept(input bundle_t b);
    int a;
    if (!ref_legal(b)) m_ill = 1;
    else if (m_n >= P_DEPTH) m_ovf = 1;
    else begin
      a = P_BASE + m_n;
      sb.push_back({a[P_AW-1:0], ref_word(b)});
      m_n++;
    end
  endtask

  // ack generator: 0 always, 1 random, 2 never, 3 stall the word at addr 1 three cycles
  initial forever begin
    @(posedge clk); #1;
    case (ack_mode)
      0: mem_ack = 1;
      1: mem_ack = ($urandom % 10) < 7;
      2: mem_ack = 0;
      default: begin
        if (mem_we && mem_addr == 1 && stall_cnt < 3) begin mem_ack = 0; stall_cnt++; end
        else mem_ack = 1;
      end
    endcase
  end

  // monitor: every acknowledged write is matched against the scoreboard
  initial begin
    logic [P_AW+15:0] e;
    bit p_stall = 0;
    logic [P_AW-1:0] p_addr = 0;
    logic [15:0] p_data = 0;
    forever begin
      @(negedge clk);
      if (mem_we && mem_ack) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write addr=%0h data=%h", mem_addr, mem_wdata);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[P_AW+15:16]));
          chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
        end
      end
      if (mem_we && !mem_ack) begin
        chk("ready_in_stall", 32'(in_ready), 0);
        if (ack_mode == 3) stall_obs++;
      end
      if (p_stall) begin
        chk("hold_we", 32'(mem_we), 1);
        chk("hold_addr", 32'(mem_addr), 32'(p_addr));
        chk("hold_data", 32'(mem_wdata), 32'(p_data));
      end
      p_stall = mem_we && !mem_ack && !reset;
      p_addr  = mem_addr;
      p_data  = mem_wdata;
    end
  end

  function automatic bundle_t mk_r(input int op, input int rd, input int rs, input int rt, input bit last);
    bundle_t b = '0;
    b.aluop = 3'(op); b.rd = 3'(rd); b.rs = 3'(rs); b.rt = 3'(rt); b.last = last;
    return b;
  endfunction

  function automatic bundle_t mk_i(input int opc, input int rd, input int rs, input int imm, input bit last);
    bundle_t b = '0;
    b.kind = 1; b.opcode = 4'(opc); b.rd = 3'(rd); b.rs = 3'(rs); b.imm = 16'(imm); b.last = last;
    return b;
  endfunction

  function automatic bundle_t rnd_bundle(input bit last);
    bundle_t b;
    int v;
    b.kind = 1'($urandom); b.aluop = 3'($urandom); b.rd = 3'($urandom);
    b.rs = 3'($urandom); b.rt = 3'($urandom);
    b.opcode = ($urandom % 4 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
    v = $urandom_range(0, 63) - 32;
    b.imm = ($urandom % 4 == 0) ? 16'($urandom) : 16'(v);
    b.last = last;
    return b;
  endfunction

  // All tasks start and return at posedge+1.
  task automatic send(input bundle_t b);
    bit got = 0;
    {in_kind, in_aluop, in_opcode, in_rd, in_rs, in_rt, in_imm, in_last} =
      {b.kind, b.aluop, b.opcode, b.rd, b.rs, b.rt, b.imm, b.last};
    in_valid = 1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin model_accept(b); acc_cyc = cyc; got = 1; end
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!got) begin checks++; failures++; $display("FAIL send_timeout in_ready=%0b expected=1", in_ready); end
  endtask

  task automatic begin_session();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    m_n = 0; m_ill = 0; m_ovf = 0;
    @(negedge clk);
    chk("sess_wc", 32'(word_count), 0);
    chk("sess_ill", 32'(err_illegal), 0);
    chk("sess_ovf", 32'(err_overflow), 0);
    chk("sess_busy", 32'(busy), 1);
    @(posedge clk); #1;
  endtask

  task automatic end_session();
    bit seen = 0;
    int ea;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 1);
    if (seen) begin
      ea = P_BASE + ((m_n < P_DEPTH - 1) ? m_n : P_DEPTH - 1);
      chk("end_sb_empty", sb.size(), 0);
      chk("end_wc", 32'(word_count), 32'(m_n));
      chk("end_ill", 32'(err_illegal), 32'(m_ill));
      chk("end_ovf", 32'(err_overflow), 32'(m_ovf));
      chk("end_addr", 32'(mem_addr), 32'(ea));
      chk("end_busy", 32'(busy), 0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 0);
    end
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int a0, n;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), P_BASE);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'({err_illegal, err_overflow}), 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_ready", 32'(in_ready), 0);
    @(posedge clk); #1;

    // single R-type word, known encoding
    ack_mode = 0;
    begin_session();
    send(mk_r(2, 1, 2, 3, 1));
    @(negedge clk);
    chk("t1_latency_we", 32'(mem_we), 1);
    chk("t1_addr", 32'(mem_addr), 0);
    chk("t1_wdata", 32'(mem_wdata), 32'h0000A298);
    end_session();

    // four back-to-back words
    begin_session();
    send(mk_r(5, 7, 6, 5, 0)); a0 = acc_cyc;
    send(mk_i(3, 4, 2, -7, 0));
    send(mk_i(7, 1, 0, 31, 0));
    send(mk_r(0, 0, 1, 2, 1));
    chk("b2b_span", 32'(acc_cyc - a0), 3);
    end_session();

    // ack withheld three cycles on the second word
    ack_mode = 3; stall_cnt = 0; stall_obs = 0;
    begin_session();
    send(mk_r(1, 1, 1, 1, 0));
    send(mk_i(2, 3, 4, -32, 0));
    send(mk_r(6, 2, 5, 7, 1));
    end_session();
    chk("stall_cycles", 32'(stall_obs), 3);

    // illegal bundles consumed without writes
    ack_mode = 1;
    begin_session();
    send(mk_r(4, 2, 2, 2, 0));
    send(mk_i(9, 1, 1, 5, 0));
    send(mk_i(3, 1, 1, 40, 0));
    send(mk_i(1, 5, 5, -33, 0));
    send(mk_i(0, 6, 6, -32, 1));
    end_session();

    // overflow: six legal bundles into a four-word window
    ack_mode = 0;
    begin_session();
    for (int i = 0; i < 6; i++) send(mk_r(i, i, i + 1, i + 2, i == 5));
    end_session();

    // reset while a write is pending
    ack_mode = 2;
    begin_session();
    send(mk_r(3, 3, 3, 3, 0));
    @(negedge clk);
    chk("pre_rst_we", 32'(mem_we), 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_wc", 32'(word_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(mem_addr), P_BASE);
    ack_mode = 1;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_resume_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1 in_valid = 0;

    // randomised sessions with gaps and stray start pulses
    for (int s = 0; s < 10; s++) begin
      begin_session();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (i > 0 && $urandom % 4 == 0) begin start = 1; @(posedge clk); #1 start = 0; end
        send(rnd_bundle(i == n - 1));
      end
      end_session();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
